// File: rtl/instr_stream_encoder_pkg.sv
// Shared definitions: RV32I opcodes, loader field-format codes and encoder FSM states.
package instr_stream_encoder_pkg;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] FMT_R      = 2'd0;
   localparam logic [1:0] FMT_LOAD   = 2'd1;
   localparam logic [1:0] FMT_STORE  = 2'd2;
   localparam logic [1:0] FMT_BRANCH = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;
endpackage

// File: rtl/instr_format_packer.sv
// Combinational packer: instruction fields to a 32-bit RV32I word plus a legality flag.
// Latency 0; no flow control (pure function of its inputs).
module instr_format_packer
   import instr_stream_encoder_pkg::*;
(
   input  logic [1:0]  i_fmt,
   input  logic [4:0]  i_rd,
   input  logic [4:0]  i_rs1,
   input  logic [4:0]  i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic [6:0]  i_funct7,
   input  logic [12:0] i_imm,
   output logic [31:0] o_word,
   output logic        o_legal
);
   always_comb begin
      o_word  = '0;
      o_legal = 1'b1;
      case (i_fmt)
         FMT_R: begin
            o_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, OP_R};
         end
         FMT_LOAD: begin
            o_word  = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
            o_legal = (i_imm[12] == i_imm[11]);
         end
         FMT_STORE: begin
            o_word  = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], OP_STORE};
            o_legal = (i_imm[12] == i_imm[11]);
         end
         default: begin
            // Branch offsets are halfword-aligned; bit 0 has no slot in the encoding.
            o_word  = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                       i_imm[4:1], i_imm[11], OP_BRANCH};
            o_legal = ~i_imm[0];
         end
      endcase
   end
endmodule

// File: rtl/instr_stream_encoder.sv
// Encodes field bundles into RV32I words and writes them sequentially to instruction memory.
// One word per 2 cycles (strobe the cycle after accept); in_ready drops while writing and in DONE.
module instr_stream_encoder
   import instr_stream_encoder_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [12:0]       in_imm,
   input  logic              in_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic [ADDR_W:0]   count,
   output logic              err,
   output logic              ovf
);
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

   state_t              r_state;
   logic                r_last;
   logic                r_in_ready;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic                r_core_hold;
   logic [ADDR_W:0]     r_count;
   logic                r_err;
   logic                r_ovf;

   logic [31:0]         w_word;
   logic                w_legal;
   logic                w_accept;
   logic                w_full;

   instr_format_packer u_packer (
      .i_fmt    (in_fmt),
      .i_rd     (in_rd),
      .i_rs1    (in_rs1),
      .i_rs2    (in_rs2),
      .i_funct3 (in_funct3),
      .i_funct7 (in_funct7),
      .i_imm    (in_imm),
      .o_word   (w_word),
      .o_legal  (w_legal)
   );

   assign w_accept = in_valid & r_in_ready;
   assign w_full   = (r_count == DEPTH_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_last      <= 1'b0;
         r_in_ready  <= 1'b1;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_core_hold <= 1'b1;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  if (w_full) begin
                     r_ovf       <= 1'b1;
                     r_in_ready  <= 1'b0;
                     r_core_hold <= 1'b0;
                     r_state     <= ST_DONE;
                  end else if (!w_legal) begin
                     r_err <= 1'b1;
                     if (in_last) begin
                        r_in_ready  <= 1'b0;
                        r_core_hold <= 1'b0;
                        r_state     <= ST_DONE;
                     end
                  end else begin
                     r_wdata    <= w_word;
                     r_we       <= 1'b1;
                     r_last     <= in_last;
                     r_in_ready <= 1'b0;
                     r_state    <= ST_WRITE;
                  end
               end
            end
            ST_WRITE: begin
               r_we    <= 1'b0;
               r_count <= r_count + 1'b1;
               // Address saturates on the final word; only start rewinds it.
               if (r_count < LAST_C)
                  r_addr <= r_addr + 1'b1;
               if (r_last) begin
                  r_core_hold <= 1'b0;
                  r_state     <= ST_DONE;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            ST_DONE: begin
               if (start) begin
                  r_addr      <= '0;
                  r_count     <= '0;
                  r_err       <= 1'b0;
                  r_ovf       <= 1'b0;
                  r_core_hold <= 1'b1;
                  r_in_ready  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_we       <= 1'b0;
               r_in_ready <= 1'b1;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign core_hold  = r_core_hold;
   assign count      = r_count;
   assign err        = r_err;
   assign ovf        = r_ovf;
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed bench for instr_stream_encoder with DEPTH=4 so the full/overflow path is reachable.
module tb_instr_stream_encoder;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [1:0]        in_fmt = '0;
   logic [4:0]        in_rd = '0;
   logic [4:0]        in_rs1 = '0;
   logic [4:0]        in_rs2 = '0;
   logic [2:0]        in_funct3 = '0;
   logic [6:0]        in_funct7 = '0;
   logic [12:0]       in_imm = '0;
   logic              in_last = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_hold;
   logic [ADDR_W:0]   count;
   logic              err;
   logic              ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_stream_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_fmt     (in_fmt),
      .in_rd      (in_rd),
      .in_rs1     (in_rs1),
      .in_rs2     (in_rs2),
      .in_funct3  (in_funct3),
      .in_funct7  (in_funct7),
      .in_imm     (in_imm),
      .in_last    (in_last),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_hold  (core_hold),
      .count      (count),
      .err        (err),
      .ovf        (ovf)
   );

   // Presents one bundle for exactly one rising edge; returns 1 time unit after it.
   task automatic drive(input logic [1:0] f, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [12:0] imm, input logic last);
      in_fmt = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, imem_we, core_hold, err, ovf} !== 5'b10100) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy/we/hold/err/ovf=%b expected 10100",
                  {in_ready, imem_we, core_hold, err, ovf});
      end
      n_checks++;
      if (imem_addr !== 8'd0 || count !== 9'd0 || imem_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got addr=%0d count=%0d wdata=%h expected 0/0/0",
                  imem_addr, count, imem_wdata);
      end
   endtask

   task automatic test_encode_stream();
      logic [1:0]  t_fmt [4] = '{2'd1, 2'd2, 2'd0, 2'd3};
      logic [4:0]  t_rd  [4] = '{5'd5, 5'd0, 5'd3, 5'd0};
      logic [4:0]  t_rs1 [4] = '{5'd2, 5'd2, 5'd1, 5'd1};
      logic [4:0]  t_rs2 [4] = '{5'd0, 5'd6, 5'd2, 5'd2};
      logic [2:0]  t_f3  [4] = '{3'd2, 3'd2, 3'd0, 3'd0};
      logic [12:0] t_imm [4] = '{13'd8, 13'd12, 13'd0, 13'h1FFC};
      logic [31:0] t_exp [4] = '{32'h00812283, 32'h00612623, 32'h002081B3, 32'hFE208EE3};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(t_fmt[i], t_rd[i], t_rs1[i], t_rs2[i], t_f3[i], 7'd0, t_imm[i], (i == 3));
         @(negedge clk);
         n_checks++;
         if (imem_we !== 1'b1 || imem_addr !== 8'(i) || imem_wdata !== t_exp[i] || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL encode_write[%0d]: got we=%b addr=%0d wdata=%h rdy=%b expected 1/%0d/%h/0",
                     i, imem_we, imem_addr, imem_wdata, in_ready, i, t_exp[i]);
         end
         @(negedge clk);
         n_checks++;
         if (imem_we !== 1'b0 || count !== 9'(i + 1)) begin
            n_fail++;
            $display("FAIL encode_count[%0d]: got we=%b count=%0d expected 0/%0d",
                     i, imem_we, count, i + 1);
         end
      end
      n_checks++;
      if (core_hold !== 1'b0 || in_ready !== 1'b0 || count !== 9'd4) begin
         n_fail++;
         $display("FAIL encode_done: got hold=%b rdy=%b count=%0d expected 0/0/4",
                  core_hold, in_ready, count);
      end
   endtask

   task automatic test_illegal();
      pulse_start();
      @(negedge clk);
      drive(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'd5, 1'b0);
      @(negedge clk);
      n_checks++;
      if (imem_we !== 1'b0 || err !== 1'b1 || count !== 9'd0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL illegal_branch: got we=%b err=%b count=%0d rdy=%b expected 0/1/0/1",
                  imem_we, err, count, in_ready);
      end
      drive(2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h0800, 1'b1);
      @(negedge clk);
      n_checks++;
      if (imem_we !== 1'b0 || err !== 1'b1 || count !== 9'd0 || imem_addr !== 8'd0) begin
         n_fail++;
         $display("FAIL illegal_load: got we=%b err=%b count=%0d addr=%0d expected 0/1/0/0",
                  imem_we, err, count, imem_addr);
      end
      n_checks++;
      if (core_hold !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL illegal_last_done: got hold=%b rdy=%b expected 0/0", core_hold, in_ready);
      end
   endtask

   task automatic test_start_collision();
      @(negedge clk);
      start = 1'b1;
      in_fmt = 2'd0; in_rd = 5'd7; in_rs1 = 5'd1; in_rs2 = 5'd2;
      in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = '0; in_last = 1'b0;
      in_valid = 1'b1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_ready: got rdy=%b expected 0", in_ready);
      end
      @(posedge clk);
      #1 start = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (imem_addr !== 8'd0 || count !== 9'd0 || err !== 1'b0 || ovf !== 1'b0 || core_hold !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_clear: got addr=%0d count=%0d err=%b ovf=%b hold=%b expected 0/0/0/0/1",
                  imem_addr, count, err, ovf, core_hold);
      end
      @(negedge clk);
      n_checks++;
      if (imem_we !== 1'b0 || in_ready !== 1'b1 || count !== 9'd0) begin
         n_fail++;
         $display("FAIL collision_no_accept: got we=%b rdy=%b count=%0d expected 0/1/0",
                  imem_we, in_ready, count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         drive(2'd0, 5'(i + 1), 5'd1, 5'd2, 3'd0, 7'd0, 13'd0, 1'b0);
         @(negedge clk);
         if (i < 4) begin
            n_checks++;
            if (imem_we !== 1'b1 || imem_addr !== 8'(i)) begin
               n_fail++;
               $display("FAIL ovf_write[%0d]: got we=%b addr=%0d expected 1/%0d", i, imem_we, imem_addr, i);
            end
            @(negedge clk);
         end else begin
            n_checks++;
            if (imem_we !== 1'b0 || ovf !== 1'b1 || count !== 9'd4 || core_hold !== 1'b0 || in_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL ovf_drop: got we=%b ovf=%b count=%0d hold=%b rdy=%b expected 0/1/4/0/0",
                        imem_we, ovf, count, core_hold, in_ready);
            end
         end
      end
   endtask

   task automatic test_reset_in_write();
      pulse_start();
      @(negedge clk);
      drive(2'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'd8, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({in_ready, imem_we, core_hold, err, ovf} !== 5'b10100 || imem_addr !== 8'd0 ||
          count !== 9'd0 || imem_wdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_in_write: got rdy/we/hold/err/ovf=%b addr=%0d count=%0d wdata=%h expected 10100/0/0/0",
                  {in_ready, imem_we, core_hold, err, ovf}, imem_addr, count, imem_wdata);
      end
   endtask

   initial begin
      test_reset();
      test_encode_stream();
      test_illegal();
      test_start_collision();
      test_overflow();
      test_reset_in_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
